// File: rtl/fir_pkg.sv
// Shared types and default sizing for the FIR stream sequencer and its capture FIFO.
package fir_pkg;

    localparam int unsigned DEF_BIT_PREC  = 16;
    localparam int unsigned DEF_TAPS      = 8;
    localparam int unsigned DEF_CAP_DEPTH = 16;

    // Full-precision FIR output width: product growth plus accumulation of TAPS terms.
    function automatic int unsigned out_width(input int unsigned bit_prec, input int unsigned taps);
        return 2 * bit_prec + taps - 1;
    endfunction

    localparam int unsigned DEF_OUT_W = out_width(DEF_BIT_PREC, DEF_TAPS);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StFlush,
        StDrain,
        StDone
    } seq_state_t;

endpackage

// File: rtl/fir_cap_fifo.sv
// First-word-fall-through FIFO for captured FIR words; exposes its fill count for credit control.
module fir_cap_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_valid,
    output logic             o_full,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_valid   = (r_count != '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_pop  = i_pop && o_valid;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= ptr_inc(r_wptr);
            if (w_do_pop)  r_rptr <= ptr_inc(r_rptr);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/fir_stream_sequencer.sv
// Replays a preloaded sample memory into CH parallel FIRs (optionally looped and zero-flushed)
// and captures their outputs into a credit-protected valid/ready stream.
module fir_stream_sequencer
    import fir_pkg::*;
#(
    parameter int unsigned BIT_PREC  = DEF_BIT_PREC,
    parameter int unsigned TAPS      = DEF_TAPS,
    parameter int unsigned CH        = 2,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned FIR_LAT   = 1,
    parameter int unsigned CAP_DEPTH = DEF_CAP_DEPTH,
    localparam int unsigned OUT_W  = out_width(BIT_PREC, TAPS),
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned NUM_W  = $clog2(DEPTH + 1),
    localparam int unsigned IN_W   = CH * BIT_PREC,
    localparam int unsigned CAP_W  = CH * OUT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load_we,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [IN_W-1:0]   i_load_data,
    input  logic              i_start,
    input  logic [NUM_W-1:0]  i_num_samples,
    input  logic              i_loop_en,
    input  logic              i_flush_en,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_fir_en,
    output logic [IN_W-1:0]   o_in_wave,
    input  logic [CAP_W-1:0]  i_out_wave,
    output logic              o_cap_valid,
    input  logic              i_cap_ready,
    output logic [CAP_W-1:0]  o_cap_data,
    output logic              o_cap_last,
    output logic              o_overflow
);

    localparam int unsigned FL_W   = (TAPS > 2) ? $clog2(TAPS - 1) : 1;
    localparam int unsigned FCNT_W = $clog2(CAP_DEPTH + 1);
    localparam int unsigned CRD_W  = $clog2(CAP_DEPTH + FIR_LAT + 3) + 1;
    localparam bit          HAS_FLUSH = (TAPS > 1);

    seq_state_t         r_state;
    seq_state_t         w_state_d;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_addr_d;
    logic [NUM_W-1:0]   r_num;
    logic [NUM_W-1:0]   w_num_d;
    logic               r_flush_en;
    logic               w_flush_en_d;
    logic [FL_W-1:0]    r_flush_cnt;
    logic [FL_W-1:0]    w_flush_cnt_d;

    logic [IN_W-1:0]    r_mem [DEPTH];
    logic [IN_W-1:0]    r_rd_data;
    logic               r_p1_vld;
    logic               r_p1_zero;
    logic               r_p1_last;
    logic               r_fir_en;
    logic               r_en_last;
    logic [IN_W-1:0]    r_in_wave;
    logic [FIR_LAT-1:0] r_en_sr;
    logic [FIR_LAT-1:0] r_last_sr;
    logic               r_overflow;

    logic               w_issue;
    logic               w_issue_zero;
    logic               w_issue_last;
    logic               w_last_addr;
    logic               w_credit;
    logic [CRD_W-1:0]   w_inflight;
    logic [FCNT_W-1:0]  w_fifo_count;
    logic               w_fifo_full;
    logic               w_fifo_valid;
    logic [CAP_W:0]     w_fifo_rdata;
    logic               w_cap_push;
    logic [FIR_LAT:0]   w_en_chain;
    logic [FIR_LAT:0]   w_last_chain;

    assign w_last_addr  = (NUM_W'(r_addr) == r_num - NUM_W'(1));
    // Everything issued but not yet written into the FIFO: read stage, fir_en stage, FIR latency.
    assign w_inflight   = CRD_W'(r_p1_vld) + CRD_W'(r_fir_en) + CRD_W'($countones(r_en_sr));
    assign w_credit     = (CRD_W'(w_fifo_count) + w_inflight) < CRD_W'(CAP_DEPTH);
    assign w_en_chain   = {r_en_sr, r_fir_en};
    assign w_last_chain = {r_last_sr, r_en_last};
    assign w_cap_push   = r_en_sr[FIR_LAT-1];

    always_comb begin
        w_state_d     = r_state;
        w_addr_d      = r_addr;
        w_num_d       = r_num;
        w_flush_en_d  = r_flush_en;
        w_flush_cnt_d = r_flush_cnt;
        w_issue       = 1'b0;
        w_issue_zero  = 1'b0;
        w_issue_last  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_num_d      = i_num_samples;
                    w_flush_en_d = i_flush_en;
                    w_addr_d     = '0;
                    w_state_d    = (i_num_samples == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (w_credit) begin
                    w_issue = 1'b1;
                    if (w_last_addr) begin
                        w_addr_d = '0;
                        if (!i_loop_en) begin
                            if (r_flush_en && HAS_FLUSH) begin
                                w_state_d     = StFlush;
                                w_flush_cnt_d = '0;
                            end else begin
                                w_state_d    = StDrain;
                                w_issue_last = 1'b1;
                            end
                        end
                    end else begin
                        w_addr_d = r_addr + ADDR_W'(1);
                    end
                end
            end
            StFlush: begin
                if (w_credit) begin
                    w_issue      = 1'b1;
                    w_issue_zero = 1'b1;
                    if (r_flush_cnt == FL_W'(TAPS - 2)) begin
                        w_issue_last = 1'b1;
                        w_state_d    = StDrain;
                    end else begin
                        w_flush_cnt_d = r_flush_cnt + FL_W'(1);
                    end
                end
            end
            StDrain: begin
                if (w_inflight == '0 && w_fifo_count == '0) w_state_d = StDone;
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_num       <= '0;
            r_flush_en  <= 1'b0;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_d;
            r_addr      <= w_addr_d;
            r_num       <= w_num_d;
            r_flush_en  <= w_flush_en_d;
            r_flush_cnt <= w_flush_cnt_d;
        end
    end

    // Sample memory: simple dual-port, never cleared by reset.
    always_ff @(posedge clk) begin
        if (i_load_we && !o_busy) r_mem[i_load_addr] <= i_load_data;
        if (w_issue)              r_rd_data          <= r_mem[r_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1_vld   <= 1'b0;
            r_p1_zero  <= 1'b0;
            r_p1_last  <= 1'b0;
            r_fir_en   <= 1'b0;
            r_en_last  <= 1'b0;
            r_in_wave  <= '0;
            r_en_sr    <= '0;
            r_last_sr  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_p1_vld  <= w_issue;
            r_p1_zero <= w_issue_zero;
            r_p1_last <= w_issue_last;
            r_fir_en  <= r_p1_vld;
            r_en_last <= r_p1_vld && r_p1_last;
            if (r_p1_vld) r_in_wave <= r_p1_zero ? '0 : r_rd_data;
            r_en_sr   <= w_en_chain[FIR_LAT-1:0];
            r_last_sr <= w_last_chain[FIR_LAT-1:0];
            if (w_cap_push && w_fifo_full && !(i_cap_ready && w_fifo_valid)) r_overflow <= 1'b1;
        end
    end

    fir_cap_fifo #(
        .WIDTH (CAP_W + 1),
        .DEPTH (CAP_DEPTH)
    ) u_cap_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_cap_push),
        .i_wdata ({r_last_sr[FIR_LAT-1], i_out_wave}),
        .i_pop   (i_cap_ready),
        .o_rdata (w_fifo_rdata),
        .o_valid (w_fifo_valid),
        .o_full  (w_fifo_full),
        .o_count (w_fifo_count)
    );

    assign o_busy      = (r_state == StRun) || (r_state == StFlush) || (r_state == StDrain);
    assign o_done      = (r_state == StDone);
    assign o_fir_en    = r_fir_en;
    assign o_in_wave   = r_in_wave;
    assign o_cap_valid = w_fifo_valid;
    assign o_cap_data  = w_fifo_rdata[CAP_W-1:0];
    assign o_cap_last  = w_fifo_valid && w_fifo_rdata[CAP_W];
    assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_fir_stream_sequencer.sv
// Directed bench for fir_stream_sequencer with a behavioural 8-tap FIR (coefficients 1..8).
module tb_fir_stream_sequencer;

    localparam int BP    = 16;
    localparam int TAPS  = 8;
    localparam int CH    = 2;
    localparam int OUT_W = 2 * BP + TAPS - 1;
    localparam int IN_W  = CH * BP;
    localparam int CAP_W = CH * OUT_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load_we = 1'b0;
    logic [7:0]       load_addr = '0;
    logic [IN_W-1:0]  load_data = '0;
    logic             start = 1'b0;
    logic [8:0]       num_samples = '0;
    logic             loop_en = 1'b0;
    logic             flush_en = 1'b0;
    logic             busy, done, fir_en, cap_valid, cap_last, overflow;
    logic [IN_W-1:0]  in_wave;
    logic [CAP_W-1:0] out_wave;
    logic             cap_ready = 1'b1;
    logic [CAP_W-1:0] cap_data;
    logic             fir_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc, first_en_cyc, done_cnt, done_cyc, last_cap_cyc;
    logic [IN_W-1:0]  ref_mem [256];
    logic [BP-1:0]    hist [CH][TAPS];
    logic [CAP_W:0]   cap_q [$];
    logic [IN_W-1:0]  en_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_stream_sequencer #(
        .BIT_PREC  (BP),
        .TAPS      (TAPS),
        .CH        (CH),
        .DEPTH     (256),
        .FIR_LAT   (1),
        .CAP_DEPTH (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_load_we     (load_we),
        .i_load_addr   (load_addr),
        .i_load_data   (load_data),
        .i_start       (start),
        .i_num_samples (num_samples),
        .i_loop_en     (loop_en),
        .i_flush_en    (flush_en),
        .o_busy        (busy),
        .o_done        (done),
        .o_fir_en      (fir_en),
        .o_in_wave     (in_wave),
        .i_out_wave    (out_wave),
        .o_cap_valid   (cap_valid),
        .i_cap_ready   (cap_ready),
        .o_cap_data    (cap_data),
        .o_cap_last    (cap_last),
        .o_overflow    (overflow)
    );

    function automatic logic [OUT_W-1:0] fir_sum(input int c, input logic [BP-1:0] x0);
        logic [OUT_W-1:0] acc;
        acc = OUT_W'(x0);
        for (int k = 1; k < TAPS; k++) acc = acc + OUT_W'(k + 1) * OUT_W'(hist[c][k-1]);
        return acc;
    endfunction

    // FIR model: one-cycle latency from fir_en/in_wave to out_wave.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || fir_clr) begin
            out_wave <= '0;
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < TAPS; k++) hist[c][k] <= '0;
        end else if (fir_en) begin
            for (int c = 0; c < CH; c++) begin
                out_wave[c*OUT_W +: OUT_W] <= fir_sum(c, in_wave[c*BP +: BP]);
                hist[c][0] <= in_wave[c*BP +: BP];
                for (int k = 1; k < TAPS; k++) hist[c][k] <= hist[c][k-1];
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (cap_valid && cap_ready) begin
                cap_q.push_back({cap_last, cap_data});
                last_cap_cyc = cyc;
            end
            if (fir_en) begin
                en_q.push_back(in_wave);
                if (first_en_cyc < 0) first_en_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Expected output n of a single-shot run from address 0 with a cleared FIR.
    function automatic logic [CAP_W-1:0] golden_y(input int n);
        logic [CAP_W-1:0] y;
        logic [OUT_W-1:0] acc;
        logic [IN_W-1:0]  w;
        y = '0;
        for (int c = 0; c < CH; c++) begin
            acc = '0;
            for (int k = 0; k < TAPS; k++) begin
                if (n - k >= 0) begin
                    w   = ref_mem[n-k];
                    acc = acc + OUT_W'(k + 1) * OUT_W'(w[c*BP +: BP]);
                end
            end
            y[c*OUT_W +: OUT_W] = acc;
        end
        return y;
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int a, input logic [IN_W-1:0] d);
        load_we   = 1'b1;
        load_addr = 8'(a);
        load_data = d;
        ref_mem[a] = d;
        tick();
        load_we = 1'b0;
    endtask

    task automatic start_run(input int num, input logic lp, input logic fl);
        cap_q.delete();
        en_q.delete();
        first_en_cyc = -1;
        done_cnt     = 0;
        fir_clr = 1'b1;
        tick();
        fir_clr     = 1'b0;
        start       = 1'b1;
        num_samples = 9'(num);
        loop_en     = lp;
        flush_en    = fl;
        start_cyc   = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        check_eq({tag, "_done_seen"}, 128'(done_cnt != 0), 128'(1));
        repeat (3) tick();
    endtask

    task automatic check_golden(input string tag, input int n);
        check_eq({tag, "_count"}, 128'(cap_q.size()), 128'(n));
        for (int i = 0; i < n && i < cap_q.size(); i++)
            check_eq($sformatf("%s_cap%0d", tag, i), 128'(cap_q[i]),
                     128'({(i == n - 1), golden_y(i)}));
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        done_cnt = 0;
        first_en_cyc = -1;
        repeat (3) tick();
        check_eq("reset_flags", 128'({busy, done, fir_en, cap_valid, cap_last, overflow}), 128'(0));
        check_eq("reset_in_wave", 128'(in_wave), 128'(0));
        rst_n = 1'b1;
        tick();

        // Ramp, single shot.
        for (int i = 0; i < 10; i++) load_word(i, {16'(16'h100 + i), 16'(i)});
        start_run(10, 1'b0, 1'b0);
        check_eq("ramp_busy", 128'(busy), 128'(1));
        wait_done("ramp", 100);
        check_golden("ramp", 10);
        check_eq("ramp_y9_hand", 128'(cap_q[9][OUT_W-1:0]), 128'(156));
        check_eq("ramp_first_en_lat", 128'(first_en_cyc - start_cyc), 128'(3));
        check_eq("ramp_done_after_drain", 128'(done_cyc - last_cap_cyc), 128'(2));
        check_eq("ramp_done_width", 128'(done_cnt), 128'(1));
        check_eq("ramp_busy_after", 128'(busy), 128'(0));

        // Impulse with flush: captures are the coefficients scaled by the impulse.
        load_word(0, {16'd1, 16'd3});
        start_run(1, 1'b0, 1'b1);
        wait_done("imp", 100);
        check_eq("imp_en_count", 128'(en_q.size()), 128'(8));
        check_eq("imp_count", 128'(cap_q.size()), 128'(8));
        for (int k = 0; k < 8 && k < cap_q.size(); k++)
            check_eq($sformatf("imp_cap%0d", k), 128'(cap_q[k]),
                     128'({(k == 7), OUT_W'(k + 1), OUT_W'(3 * (k + 1))}));

        // Looping: drop loop_en during the third pass.
        for (int i = 0; i < 4; i++) load_word(i, {16'(16'h20 + i), 16'(16'h10 + i)});
        start_run(4, 1'b1, 1'b0);
        n = 0;
        while (en_q.size() < 7 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        tick();
        loop_en = 1'b0;
        wait_done("loop", 100);
        check_eq("loop_en_count", 128'(en_q.size()), 128'(12));
        for (int i = 0; i < 12 && i < en_q.size(); i++)
            check_eq($sformatf("loop_addr%0d", i), 128'(en_q[i]),
                     128'({16'(16'h20 + i % 4), 16'(16'h10 + i % 4)}));
        check_eq("loop_cap_count", 128'(cap_q.size()), 128'(12));
        if (cap_q.size() == 12) begin
            check_eq("loop_last11", 128'(cap_q[11][CAP_W]), 128'(1));
            check_eq("loop_last10", 128'(cap_q[10][CAP_W]), 128'(0));
        end

        // Backpressure: only CAP_DEPTH samples may be issued while ready is low.
        for (int i = 0; i < 40; i++) load_word(i, {16'(1000 - i), 16'(i)});
        cap_ready = 1'b0;
        start_run(40, 1'b0, 1'b0);
        repeat (80) tick();
        check_eq("bp_en_stall", 128'(en_q.size()), 128'(16));
        check_eq("bp_overflow", 128'(overflow), 128'(0));
        check_eq("bp_valid", 128'(cap_valid), 128'(1));
        check_eq("bp_busy", 128'(busy), 128'(1));
        cap_ready = 1'b1;
        wait_done("bp", 300);
        check_golden("bp", 40);
        check_eq("bp_overflow_end", 128'(overflow), 128'(0));

        // Zero-length run.
        start_run(0, 1'b0, 1'b0);
        wait_done("zero", 10);
        check_eq("zero_en", 128'(en_q.size()), 128'(0));
        check_eq("zero_cap", 128'(cap_q.size()), 128'(0));

        // start and load_we while busy are dropped.
        start_run(10, 1'b0, 1'b0);
        repeat (2) tick();
        start       = 1'b1;
        num_samples = 9'd5;
        load_we     = 1'b1;
        load_addr   = 8'd3;
        load_data   = 32'hDEAD_BEEF;
        tick();
        start   = 1'b0;
        load_we = 1'b0;
        wait_done("busy_drop", 100);
        check_eq("busy_drop_en", 128'(en_q.size()), 128'(10));
        check_golden("busy_drop", 10);
        repeat (10) tick();
        check_eq("busy_drop_no_rerun", 128'(done_cnt), 128'(1));

        // Asynchronous reset mid-run, then rerun from the untouched memory.
        start_run(40, 1'b0, 1'b0);
        repeat (8) tick();
        check_eq("rst_midrun_busy", 128'(busy), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_flags", 128'({busy, done, fir_en, cap_valid, cap_last, overflow}),
                 128'(0));
        check_eq("rst_async_in_wave", 128'(in_wave), 128'(0));
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check_eq("rst_no_done", 128'(done_cnt), 128'(0));
        start_run(10, 1'b0, 1'b0);
        wait_done("rerun", 100);
        check_golden("rerun", 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
